// File: rtl/run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// run_ctrl_pkg : state encoding and default constants for the run controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CORE_RST = 3'd1,
    ST_RUN      = 3'd2,
    ST_DONE     = 3'd3,
    ST_TIMEOUT  = 3'd4
  } state_e;

  localparam logic [7:0]  DONE_PC_DEF    = 8'hFF;
  localparam logic [15:0] MAX_CYCLES_DEF = 16'hFFFF;
  localparam int unsigned RST_CYCLES_DEF = 2;

endpackage

`default_nettype wire

// File: rtl/cycle_cnt.sv
// ---------------------------------------------------------------------------
// cycle_cnt : saturating up-counter with clear, increment and hold
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cycle_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl : sequences core reset, run, completion and timeout of a program
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter logic [7:0]  DONE_PC    = DONE_PC_DEF,
  parameter logic [15:0] MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  pc,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycles
);

  localparam logic [3:0] HOLD_LOAD = 4'(RST_CYCLES);

  state_e     state_q, state_d;
  logic       start_q;
  logic [3:0] hold_q, hold_d;
  logic       start_edge;
  logic       cnt_clr;
  logic       cnt_inc;

  assign start_edge = start & ~start_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      hold_q  <= hold_d;
    end
  end

  // Dropping start aborts only an active run; finished results stay latched.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start_edge) begin
          state_d = ST_CORE_RST;
          hold_d  = HOLD_LOAD;
          cnt_clr = 1'b1;
        end
      end
      ST_CORE_RST: begin
        if (!start) begin
          state_d = ST_IDLE;
          hold_d  = 4'd0;
        end else begin
          hold_d = hold_q - 1'b1;
          if (hold_q == 4'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (pc == DONE_PC) begin
          state_d = ST_DONE;
          cnt_inc = 1'b1;
        end else if (cycles == MAX_CYCLES) begin
          state_d = ST_TIMEOUT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    core_rst = (state_q != ST_RUN);
    busy     = (state_q == ST_CORE_RST) || (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
    timeout  = (state_q == ST_TIMEOUT);
  end

  cycle_cnt #(
    .WIDTH (16)
  ) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cycles)
  );

endmodule

`default_nettype wire

// File: tb/tb_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_run_ctrl : scoreboard bench for run_ctrl against a run-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_run_ctrl;

  localparam logic [7:0]  DONE_PC    = 8'hFF;
  localparam logic [15:0] MAX_CYCLES = 16'd20;
  localparam int          RST_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  pc = 8'h00;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycles;

  always #5 clk = ~clk;

  run_ctrl #(
    .DONE_PC    (DONE_PC),
    .MAX_CYCLES (MAX_CYCLES),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pc       (pc),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .cycles   (cycles)
  );

  typedef struct packed {
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycles;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Run-level model: a run is "holding" for some cycles, then "running"
  // until it finishes, is aborted, or is wiped by reset.
  bit m_prev_start = 1'b0;
  bit m_running    = 1'b0;
  bit m_done       = 1'b0;
  bit m_to         = 1'b0;
  int m_hold_left  = 0;
  int m_cycles     = 0;

  task automatic model_step(input bit r, input bit s, input logic [7:0] p);
    bit edge_seen;
    edge_seen = s && !m_prev_start;
    if (!r) begin
      m_running   = 1'b0;
      m_done      = 1'b0;
      m_to        = 1'b0;
      m_hold_left = 0;
      m_cycles    = 0;
    end else if (m_hold_left > 0 || m_running) begin
      if (!s) begin
        m_hold_left = 0;
        m_running   = 1'b0;
      end else if (m_hold_left > 0) begin
        m_hold_left--;
        if (m_hold_left == 0) m_running = 1'b1;
      end else if (p == DONE_PC) begin
        m_cycles  = (m_cycles < 65535) ? m_cycles + 1 : 65535;
        m_done    = 1'b1;
        m_running = 1'b0;
      end else if (m_cycles == int'(MAX_CYCLES)) begin
        m_to      = 1'b1;
        m_running = 1'b0;
      end else begin
        m_cycles++;
      end
    end else if (edge_seen) begin
      m_hold_left = RST_CYCLES;
      m_cycles    = 0;
      m_done      = 1'b0;
      m_to        = 1'b0;
    end
    m_prev_start = r ? s : 1'b0;
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic cyc(input bit r, input bit s, input logic [7:0] p);
    obs_t e;
    @(negedge clk);
    rst   = r;
    start = s;
    pc    = p;
    model_step(r, s, p);
    e.core_rst = !m_running;
    e.busy     = m_running || (m_hold_left > 0);
    e.done     = m_done;
    e.timeout  = m_to;
    e.cycles   = 16'(m_cycles);
    exp_q.push_back(e);
  endtask

  task automatic start_run();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, 8'hFF);
  endtask

  task automatic run_edges(input int n, input logic [7:0] p);
    repeat (n) cyc(1'b1, 1'b1, p);
  endtask

  obs_t mon_exp;
  obs_t mon_act;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {core_rst, busy, done, timeout, cycles};
      checks++;
      if (mon_act !== mon_exp) begin
        failures++;
        $display("FAIL outputs t=%0t got core_rst=%b busy=%b done=%b timeout=%b cycles=%0d expected core_rst=%b busy=%b done=%b timeout=%b cycles=%0d",
                 $time, mon_act.core_rst, mon_act.busy, mon_act.done, mon_act.timeout, mon_act.cycles,
                 mon_exp.core_rst, mon_exp.busy, mon_exp.done, mon_exp.timeout, mon_exp.cycles);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit         rs;
    bit         ss;
    logic [7:0] ps;

    // Reset with start high, then release with start still high: no run.
    repeat (3) cyc(1'b0, 1'b1, 8'h00);
    repeat (4) cyc(1'b1, 1'b1, 8'h00);

    // Nominal run ending at the done pc, then start falls in DONE.
    start_run();
    run_edges(10, 8'h00);
    cyc(1'b1, 1'b1, 8'hFF);
    repeat (3) cyc(1'b1, 1'b1, 8'h00);
    repeat (2) cyc(1'b1, 1'b0, 8'hFF);

    // Restart from DONE into a timeout, held for a while.
    start_run();
    run_edges(26, 8'h00);
    cyc(1'b1, 1'b0, 8'hFF);

    // Done pc on the same edge the limit is reached.
    start_run();
    run_edges(20, 8'h33);
    cyc(1'b1, 1'b1, 8'hFF);
    repeat (2) cyc(1'b1, 1'b1, 8'h00);

    // Abort after five RUN edges, then restart.
    start_run();
    run_edges(5, 8'h00);
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    start_run();
    run_edges(7, 8'h12);

    // Reset mid-run with start held, then start must toggle again.
    repeat (2) cyc(1'b0, 1'b1, 8'h00);
    repeat (3) cyc(1'b1, 1'b1, 8'hFF);
    start_run();
    run_edges(4, 8'h00);
    cyc(1'b1, 1'b1, 8'hFF);

    // Randomized traffic.
    ss = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(299) != 0);
      if ($urandom_range(29) == 0) ss = ~ss;
      ps = ($urandom_range(24) == 0) ? 8'hFF : 8'($urandom_range(254));
      cyc(rs, ss, ps);
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got %0d pending expectations required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The block SHALL have parameter DONE_PC, default 8'hFF: the pc value that marks program completion.
REQ-002 The block SHALL have parameter MAX_CYCLES, default 16'hFFFF: the RUN-cycle limit before a timeout.
REQ-003 The block SHALL have parameter RST_CYCLES, default 2: the number of cycles the core is held in reset before RUN (legal range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: run request level, acted on at its rising edge.
REQ-007 The block SHALL have port pc, input, 8 bits: the core program counter.
REQ-008 The block SHALL have port core_rst, output, 1 bit: active-high reset to the core; the datamem is written only while it is 0.
REQ-009 The block SHALL have port busy, output, 1 bit: high in states CORE_RST and RUN.
REQ-010 The block SHALL have port done, output, 1 bit: high only in state DONE.
REQ-011 The block SHALL have port timeout, output, 1 bit: high only in state TIMEOUT.
REQ-012 The block SHALL have port cycles, output, 16 bits: the RUN-cycle count of the current or last run.

Function
REQ-013 The FSM SHALL have exactly five states: IDLE, CORE_RST, RUN, DONE, TIMEOUT; all outputs are registered or decoded from the state register only (no combinational path from pc or start).
REQ-014 start_q SHALL register start every cycle, and a start edge is defined as start & ~start_q.
REQ-015 In IDLE, DONE and TIMEOUT, a start edge SHALL move the FSM to CORE_RST, load the hold counter with RST_CYCLES, clear cycles to 0, and deassert done/timeout on that edge.
REQ-016 In CORE_RST, core_rst SHALL be 1, the hold counter SHALL decrement each edge, and the FSM SHALL enter RUN on the edge where the counter equals 1, giving exactly RST_CYCLES cycles of core_rst=1 after the start edge.
REQ-017 In RUN, core_rst SHALL be 0, and each rising edge in RUN SHALL evaluate, in priority order: pc==DONE_PC gives DONE with cycles+1; else cycles==MAX_CYCLES gives TIMEOUT with cycles held; else stay in RUN with cycles+1.
REQ-018 The done check SHALL win over timeout when both conditions hold on the same edge.
REQ-019 cycles SHALL never wrap: the maximum is MAX_CYCLES in TIMEOUT, and MAX_CYCLES+1 truncated to 16 bits is not possible because the done increment is saturating at 16'hFFFF.
REQ-020 In DONE and TIMEOUT, core_rst SHALL be 1 (core frozen, no further memory writes), and cycles SHALL hold.
REQ-021 If start is 0 on any edge in CORE_RST or RUN, the run SHALL abort: FSM goes to IDLE, core_rst=1, cycles holds, and done=timeout=0.
REQ-022 In DONE and TIMEOUT, start falling SHALL have no effect; only a new start edge leaves these states.
REQ-023 done SHALL rise one cycle after the edge on which pc==DONE_PC is sampled in RUN; pc SHALL be ignored outside RUN.

Reset
REQ-024 While rst is 0 at a rising edge: state=IDLE, core_rst=1, busy=0, done=0, timeout=0, cycles=0, start_q=0, hold counter=0.
REQ-025 Reset SHALL take priority over every transition, including mid-RUN.
REQ-026 start held high through reset release SHALL NOT start a run, because start_q resets to 0 and then samples 1, so a new low-to-high edge is required.

Structure
REQ-027 Package run_ctrl_pkg SHALL hold the state enum (3-bit encoding) and default constants DONE_PC_DEF, MAX_CYCLES_DEF and RST_CYCLES_DEF.
REQ-028 The saturating 16-bit counter (clear, inc, hold) SHALL be one sub-module named cycle_cnt; the FSM, hold counter and edge detect stay in run_ctrl.

Verification (RST_CYCLES=2 unless stated)
REQ-029 Nominal run: rst released, start 0->1, pc=0x00 for 10 RUN edges then 0xFF -> core_rst=1 for exactly 2 cycles, then busy=1, done=1 one cycle after the FF sample, cycles=11, core_rst=1.
REQ-030 Timeout: MAX_CYCLES=20, pc never 0xFF -> timeout=1 after 21 RUN edges, cycles=20, done=0, core_rst=1.
REQ-031 Simultaneous events: MAX_CYCLES=20, pc=0xFF on the edge where cycles==20 -> done=1, timeout=0, cycles=21.
REQ-032 Abort: start dropped after 5 RUN edges -> IDLE next cycle, cycles=5, done=0, core_rst=1; a new start edge restarts with cycles cleared to 0.
REQ-033 Reset mid-run: rst=0 at RUN cycle 7 with start held 1 -> all outputs at reset values; after release, no run begins until start toggles 0->1.
REQ-034 Restart from DONE: start 1->0->1 while in DONE -> done clears on the edge, CORE_RST for 2 cycles, cycles=0.
